// File: rtl/ccg_bist_pkg.sv
// Shared types and helpers for the CCG BIST driver: FSM states, default widths,
// LFSR/MISR tap masks and their single-step update functions.
package ccg_bist_pkg;

  localparam int unsigned IN_W_DEF  = 26;
  localparam int unsigned OUT_W_DEF = 30;
  localparam int unsigned CNT_W     = 17;

  // Tap masks: bit positions 25,5,1,0 (LFSR) and 29,5,3,0 (MISR)
  localparam logic [IN_W_DEF-1:0]  LFSR_TAPS = 26'h2000023;
  localparam logic [OUT_W_DEF-1:0] MISR_TAPS = 30'h20000029;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic logic [IN_W_DEF-1:0] lfsr_next(input logic [IN_W_DEF-1:0] v);
    return {v[IN_W_DEF-2:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [OUT_W_DEF-1:0] misr_next(input logic [OUT_W_DEF-1:0] s,
                                                     input logic [OUT_W_DEF-1:0] d);
    return {s[OUT_W_DEF-2:0], ^(s & MISR_TAPS)} ^ d;
  endfunction

endpackage

// File: rtl/ccg_bist_driver_if.sv
// Stimulus/response stream between the BIST driver (master) and the CUT wrapper (slave).
interface ccg_bist_driver_if #(
  parameter int unsigned IN_W  = ccg_bist_pkg::IN_W_DEF,
  parameter int unsigned OUT_W = ccg_bist_pkg::OUT_W_DEF
) ();

  logic             vec_valid;
  logic             vec_ready;
  logic [IN_W-1:0]  vec_data;
  logic             resp_valid;
  logic [OUT_W-1:0] resp_data;

  modport master (
    output vec_valid,
    output vec_data,
    input  vec_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  vec_valid,
    input  vec_data,
    output vec_ready,
    output resp_valid,
    output resp_data
  );

endinterface

// File: rtl/ccg_misr.sv
// Multiple-input signature register compacting CUT responses; clear has priority.
module ccg_misr
  import ccg_bist_pkg::*;
#(
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [OUT_W-1:0] data_i,
  output logic [OUT_W-1:0] sig_o
);

  logic [OUT_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = misr_next(sig_q, data_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/ccg_bist_driver.sv
// BIST initiator: issues stimulus vectors, tracks outstanding responses and checks the
// MISR signature. Define CCG_BIST_EXHAUSTIVE_EN for counter stimulus instead of LFSR.
module ccg_bist_driver
  import ccg_bist_pkg::*;
#(
  parameter int unsigned    IN_W      = IN_W_DEF,
  parameter int unsigned    OUT_W     = OUT_W_DEF,
  parameter int unsigned    NUM_VEC   = 1024,
  parameter logic [IN_W-1:0] SEED     = IN_W'(1),
  parameter int unsigned    MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OUT_W-1:0]  exp_sig,
  ccg_bist_driver_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [OUT_W-1:0]  signature,
  output logic              err_unexp
);

`ifdef CCG_BIST_EXHAUSTIVE_EN
  localparam int unsigned RUN_LEN = (IN_W >= 17) ? NUM_VEC :
                                    ((NUM_VEC < (32'd1 << IN_W)) ? NUM_VEC : (32'd1 << IN_W));
`else
  localparam int unsigned RUN_LEN = NUM_VEC;
`endif
  localparam logic [CNT_W-1:0] RUN_LEN_C   = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] MAX_OUTST_C = CNT_W'(MAX_OUTST);

  state_e           state_q, state_d;
  logic             vec_valid_q, vec_valid_d;
  logic [IN_W-1:0]  vec_q, vec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             err_q, err_d;
  logic [OUT_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] iss_q, iss_d;
  logic [CNT_W-1:0] rsp_q, rsp_d;
  logic [CNT_W-1:0] outst_q, outst_d;

  logic             xfer, rsp_acc, rsp_unexp, start_ok;
  logic [IN_W-1:0]  stim_init, stim_next;
  logic [OUT_W-1:0] sig;

`ifdef CCG_BIST_EXHAUSTIVE_EN
  assign stim_init = '0;
  assign stim_next = vec_q + IN_W'(1);
`else
  assign stim_init = SEED;
  assign stim_next = lfsr_next(vec_q);
`endif

  assign xfer      = vec_valid_q & bus.vec_ready;
  assign rsp_acc   = bus.resp_valid & (outst_q != '0);
  assign rsp_unexp = bus.resp_valid & (outst_q == '0);
  assign start_ok  = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    pass_d  = pass_q;
    err_d   = err_q | rsp_unexp;
    exp_d   = exp_q;
    iss_d   = iss_q;
    rsp_d   = rsp_q;
    outst_d = outst_q;

    if (xfer && !rsp_acc) begin
      outst_d = outst_q + CNT_W'(1);
    end else if (!xfer && rsp_acc) begin
      outst_d = outst_q - CNT_W'(1);
    end
    if (xfer) begin
      vec_d = stim_next;
      iss_d = iss_q + CNT_W'(1);
    end
    if (rsp_acc) begin
      rsp_d = rsp_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d = ST_RUN;
          vec_d   = stim_init;
          iss_d   = '0;
          rsp_d   = '0;
          outst_d = '0;
          exp_d   = exp_sig;
          pass_d  = 1'b0;
          // A stray response in the start cycle still gets flagged
          err_d   = rsp_unexp;
        end
      end
      ST_RUN: begin
        if (xfer && (iss_q == RUN_LEN_C - CNT_W'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((outst_q == '0) && (rsp_q == RUN_LEN_C)) begin
          state_d = ST_DONE;
          pass_d  = (sig == exp_q) && !err_d;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Valid is recomputed from next-state so it never drops while a vector is pending
    vec_valid_d = (state_d == ST_RUN) && (outst_d < MAX_OUTST_C);
    busy_d      = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vec_valid_q <= 1'b0;
      vec_q       <= SEED;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= 1'b0;
      exp_q       <= '0;
      iss_q       <= '0;
      rsp_q       <= '0;
      outst_q     <= '0;
    end else begin
      state_q     <= state_d;
      vec_valid_q <= vec_valid_d;
      vec_q       <= vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      exp_q       <= exp_d;
      iss_q       <= iss_d;
      rsp_q       <= rsp_d;
      outst_q     <= outst_d;
    end
  end

  ccg_misr #(
    .OUT_W(OUT_W)
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start_ok),
    .en_i  (rsp_acc),
    .data_i(bus.resp_data),
    .sig_o (sig)
  );

  assign bus.vec_valid = vec_valid_q;
  assign bus.vec_data  = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign signature     = sig;
  assign err_unexp     = err_q;

endmodule

// File: tb/tb_ccg_bist_driver.sv
// Directed bench for ccg_bist_driver: vector scoreboard, replicate-x0 CUT model and
// reference MISR; a second instance exercises the outstanding-vector limit.
module tb_ccg_bist_driver;

`ifdef CCG_BIST_EXHAUSTIVE_EN
  localparam int unsigned A_NV = 4;
`else
  localparam int unsigned A_NV = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b;
  logic [29:0] exp_sig_a, exp_sig_b, sig_a, sig_b;
  logic        busy_a, done_a, pass_a, err_a;
  logic        busy_b, done_b, pass_b, err_b;

  ccg_bist_driver_if #(.IN_W(26), .OUT_W(30)) ifa ();
  ccg_bist_driver_if #(.IN_W(26), .OUT_W(30)) ifb ();

  ccg_bist_driver #(
    .IN_W(26), .OUT_W(30), .NUM_VEC(A_NV), .SEED(26'h0000001), .MAX_OUTST(4)
  ) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .exp_sig(exp_sig_a), .bus(ifa),
    .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a), .err_unexp(err_a)
  );

  ccg_bist_driver #(
    .IN_W(26), .OUT_W(30), .NUM_VEC(6), .SEED(26'h0000001), .MAX_OUTST(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .exp_sig(exp_sig_b), .bus(ifb),
    .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b), .err_unexp(err_b)
  );

  int          checks = 0;
  int          failures = 0;
  int          xfer_a, xfer_b, resp_a;
  logic        rdy_a, auto_resp;
  logic [25:0] ref_vecs [A_NV];
  logic [25:0] exp_q [$];
  logic        pend_q [$];
  logic [29:0] sig_ref;

  function automatic logic [29:0] misr_ref(input logic [29:0] s, input logic [29:0] d);
    return {s[28:0], s[29] ^ s[5] ^ s[3] ^ s[0]} ^ d;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_ref();
    logic [29:0] s;
    exp_q.delete();
    pend_q.delete();
    s = '0;
    for (int i = 0; i < A_NV; i++) begin
      exp_q.push_back(ref_vecs[i]);
      s = misr_ref(s, {30{ref_vecs[i][0]}});
    end
    sig_ref = s;
  endtask

  // One cycle: sample #1 after the edge, drive the CUT model, score pending transfers
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_resp) begin
      if (pend_q.size() > 0) begin
        ifa.resp_valid = 1'b1;
        ifa.resp_data  = {30{pend_q.pop_front()}};
        resp_a++;
      end else begin
        ifa.resp_valid = 1'b0;
        ifa.resp_data  = '0;
      end
    end
    ifa.vec_ready = rdy_a;
    if (ifa.vec_valid && ifa.vec_ready) begin
      xfer_a++;
      if (exp_q.size() == 0) check("vec_extra", 64'(ifa.vec_data), 64'hDEAD);
      else check("vec_data", 64'(ifa.vec_data), 64'(exp_q.pop_front()));
      pend_q.push_back(ifa.vec_data[0]);
    end
    if (ifb.vec_valid && ifb.vec_ready) xfer_b++;
  endtask

  task automatic start_run_a(input logic [29:0] es, input logic rdy);
    exp_sig_a = es;
    rdy_a     = rdy;
    auto_resp = 1'b1;
    xfer_a    = 0;
    resp_a    = 0;
    start_a   = 1'b1;
    tick();
    start_a   = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    for (int i = 0; i < 200 && !done_a; i++) tick();
    check(tag, 64'(done_a), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef CCG_BIST_EXHAUSTIVE_EN
    for (int i = 0; i < A_NV; i++) ref_vecs[i] = 26'(i);
`else
    ref_vecs[0] = 26'h1;
    ref_vecs[1] = 26'h3;
    ref_vecs[2] = 26'h6;
`endif
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    exp_sig_a = '0; exp_sig_b = '0;
    rdy_a = 1'b0; auto_resp = 1'b1;
    xfer_a = 0; xfer_b = 0; resp_a = 0; sig_ref = '0;
    ifa.vec_ready = 1'b0; ifa.resp_valid = 1'b0; ifa.resp_data = '0;
    ifb.vec_ready = 1'b0; ifb.resp_valid = 1'b0; ifb.resp_data = '0;
    repeat (3) tick();
    check("rst_vec_valid", 64'(ifa.vec_valid), 64'd0);
    check("rst_vec_data", 64'(ifa.vec_data), 64'h1);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_pass", 64'(pass_a), 64'd0);
    check("rst_sig", 64'(sig_a), 64'd0);
    check("rst_err", 64'(err_a), 64'd0);
    rst = 1'b0;

    // Stream sequence with matching signature
    load_ref();
    start_run_a(sig_ref, 1'b1);
    check("s1_busy_run", 64'(busy_a), 64'd1);
    wait_done_a("s1_done");
    check("s1_sig", 64'(sig_a), 64'(sig_ref));
    check("s1_pass", 64'(pass_a), 64'd1);
    check("s1_busy_done", 64'(busy_a), 64'd0);
    check("s1_xfers", 64'(xfer_a), 64'(A_NV));
    check("s1_resps", 64'(resp_a), 64'(A_NV));
    check("s1_sb_left", 64'(exp_q.size()), 64'd0);

    // Same stream, expected signature off by one bit
    load_ref();
    start_run_a(sig_ref ^ 30'h1, 1'b1);
    check("s2_done_drop", 64'(done_a), 64'd0);
    wait_done_a("s2_done");
    check("s2_sig", 64'(sig_a), 64'(sig_ref));
    check("s2_pass", 64'(pass_a), 64'd0);

    // Backpressure: first vector must hold
    load_ref();
    start_run_a(sig_ref, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 64'(ifa.vec_valid), 64'd1);
      check("bp_data", 64'(ifa.vec_data), 64'(ref_vecs[0]));
    end
    check("bp_no_xfer", 64'(xfer_a), 64'd0);
    rdy_a = 1'b1;
    tick();
    check("bp_first_xfer", 64'(xfer_a), 64'd1);
    wait_done_a("bp_done");
    check("bp_pass", 64'(pass_a), 64'd1);

    // Stray response in IDLE
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    auto_resp = 1'b0;
    ifa.resp_valid = 1'b1;
    ifa.resp_data  = 30'h2AAA5555;
    tick();
    ifa.resp_valid = 1'b0;
    tick();
    check("stray_err", 64'(err_a), 64'd1);
    check("stray_sig", 64'(sig_a), 64'd0);
    load_ref();
    start_run_a(sig_ref, 1'b1);
    check("stray_clear", 64'(err_a), 64'd0);
    wait_done_a("stray_done");
    check("stray_pass", 64'(pass_a), 64'd1);

    // Outstanding limit on instance B (no responses returned)
    xfer_b = 0;
    ifb.vec_ready = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (8) tick();
    check("ol_xfers", 64'(xfer_b), 64'd4);
    check("ol_valid_low", 64'(ifb.vec_valid), 64'd0);
    ifb.resp_valid = 1'b1;
    ifb.resp_data  = 30'h1;
    tick();
    ifb.resp_valid = 1'b0;
    repeat (6) tick();
    check("ol_one_more", 64'(xfer_b), 64'd5);
    check("ol_valid_low2", 64'(ifb.vec_valid), 64'd0);
    check("ol_busy", 64'(busy_b), 64'd1);

    // Reset in RUN after two transfers
    load_ref();
    start_run_a(sig_ref, 1'b1);
    for (int i = 0; i < 20 && xfer_a < 2; i++) tick();
    rdy_a = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_valid", 64'(ifa.vec_valid), 64'd0);
    check("mr_busy", 64'(busy_a), 64'd0);
    check("mr_sig", 64'(sig_a), 64'd0);
    check("mr_seed", 64'(ifa.vec_data), 64'h1);
    load_ref();
    start_run_a(sig_ref, 1'b1);
    check("mr_restart_data", 64'(ifa.vec_data), 64'(ref_vecs[0]));
    wait_done_a("mr_done");
    check("mr_pass", 64'(pass_a), 64'd1);
    check("mr_resps", 64'(resp_a), 64'(A_NV));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
